// File: rtl/gated_latch_ctrl_pkg.sv
// Shared types for the gated SR latch sequencer.
// State encoding, operation codes and a small sizing helper.
package gated_latch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ENABLE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_CHECK  = 3'd4
   } state_e;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/gated_latch_ctrl_rr_arbiter.sv
// Round-robin arbiter: lowest offset from the pointer wins.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req_i,
   input  logic          take_i,
   output logic          any_o,
   output logic [IW-1:0] idx_o
);

   logic [IW-1:0] ptr_q, ptr_d;

   // Search from the pointer, wrapping; closest requester wins.
   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] pos;
      any_o = 1'b0;
      idx_o = ptr_q;
      sum   = '0;
      pos   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, ptr_q} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         pos = sum[IW-1:0];
         if (req_i[pos]) begin
            any_o = 1'b1;
            idx_o = pos;
         end
      end
   end

   // Next pointer is the index after the winner.
   always_comb begin
      ptr_d = ptr_q;
      if (take_i && any_o) begin
         if (idx_o == IW'(N - 1)) ptr_d = '0;
         else                     ptr_d = idx_o + IW'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/gated_latch_ctrl.sv
// Shares one gated SR latch between requesters with a
// setup/enable/hold write sequence and Q/Q_bar readback.
module gated_latch_ctrl #(
   parameter int NUM_REQ   = 4,
   parameter int SETUP_CYC = 1,
   parameter int EN_CYC    = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_op,
   output logic [NUM_REQ-1:0] req_ack,
   output logic               req_err,
   output logic               latch_s,
   output logic               latch_r,
   output logic               latch_en,
   input  logic               latch_q,
   input  logic               latch_qb,
   output logic               busy,
   output logic [7:0]         err_cnt
);

   import gated_latch_ctrl_pkg::*;

   localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int MAXC = max3(SETUP_CYC, EN_CYC, HOLD_CYC);
   localparam int CW   = $clog2(MAXC + 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        gnt_q, gnt_d;
   logic                 op_q, op_d;
   logic                 s_q, s_d;
   logic                 r_q, r_d;
   logic                 en_q, en_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic [7:0]           ecnt_q, ecnt_d;
   logic                 arb_take;
   logic                 arb_any;
   logic [IW-1:0]        arb_idx;
   logic                 rd_err;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req_i  (req_valid),
      .take_i (arb_take),
      .any_o  (arb_any),
      .idx_o  (arb_idx)
   );

   assign rd_err = (latch_q != op_q) || (latch_qb != ~op_q);

   // Sequencer: S/R settle before EN rises and stay put until
   // EN has been low for the hold phase; S/R clear only in CHECK.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      op_d     = op_q;
      s_d      = s_q;
      r_d      = r_q;
      en_d     = 1'b0;
      ack_d    = '0;
      err_d    = 1'b0;
      ecnt_d   = ecnt_q;
      arb_take = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            s_d = 1'b0;
            r_d = 1'b0;
            if (arb_any) begin
               arb_take = 1'b1;
               gnt_d    = arb_idx;
               op_d     = req_op[arb_idx];
               s_d      = (req_op[arb_idx] == OP_SET);
               r_d      = (req_op[arb_idx] == OP_CLR);
               cnt_d    = CW'(SETUP_CYC - 1);
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               en_d    = 1'b1;
               cnt_d   = CW'(EN_CYC - 1);
               state_d = ST_ENABLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_ENABLE: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(HOLD_CYC - 1);
               state_d = ST_HOLD;
            end else begin
               en_d  = 1'b1;
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               s_d          = 1'b0;
               r_d          = 1'b0;
               ack_d[gnt_q] = 1'b1;
               err_d        = rd_err;
               if (rd_err && ecnt_q != 8'hFF)
                  ecnt_d = ecnt_q + 8'd1;
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            s_d     = 1'b0;
            r_d     = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset drops the latch pins at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         op_q    <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         en_q    <= 1'b0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         ecnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         s_q     <= s_d;
         r_q     <= r_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign latch_s  = s_q;
   assign latch_r  = r_q;
   assign latch_en = en_q;
   assign req_ack  = ack_q;
   assign req_err  = err_q;
   assign busy     = busy_q;
   assign err_cnt  = ecnt_q;

endmodule

// File: doc/gated_latch_ctrl.md
Name: gated_latch_ctrl

Overview:
Sequencer and arbiter that shares one gated SR latch between NUM_REQ requesters. It drives the latch S/R/EN pins with a fixed setup, enable and hold sequence, so S=R=1 is never presented and S/R never change while EN=1. It reads back Q/Q_bar to confirm each write, then acks the requester with a pass/fail flag. It sits between software-facing requesters and the latch primitive, which this block does not reset.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
SETUP_CYC, 1, cycles S/R are stable with EN=0 before enable (>=1)
EN_CYC, 2, cycles EN is held high (>=1)
HOLD_CYC, 1, cycles S/R are held with EN=0 after enable (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  per-requester request; held until acked
req_op  input  NUM_REQ  per-requester operation: 1=set, 0=clear; stable while valid
req_ack  output  NUM_REQ  one-cycle completion pulse, one-hot
req_err  output  1  valid with req_ack; 1 = readback mismatch
latch_s  output  1  to latch S
latch_r  output  1  to latch R
latch_en  output  1  to latch EN
latch_q  input  1  latch Q readback
latch_qb  input  1  latch Q_bar readback
busy  output  1  high in any state except IDLE
err_cnt  output  8  saturating count of failed transactions

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; rr pointer=0; err_cnt=0. Reset mid-sequence drops EN/S/R at that edge; the latch keeps whatever value it holds.
- FSM: IDLE -> SETUP -> ENABLE -> HOLD -> CHECK -> IDLE. All outputs are registered.
- IDLE: if any req_valid is high, grant round-robin starting at the index after the last grant (index 0 after reset). Capture grant index and req_op. Go to SETUP.
- SETUP (SETUP_CYC cycles): latch_s=op, latch_r=~op, latch_en=0.
- ENABLE (EN_CYC cycles): S/R unchanged, latch_en=1.
- HOLD (HOLD_CYC cycles): latch_en=0, S/R unchanged.
- CHECK (1 cycle): S/R=0. req_ack[grant]=1. req_err=1 if latch_q!=op or latch_qb!=~op. On error, err_cnt increments and saturates at 255.
- Latency: valid sampled at edge k in IDLE; ack is high during cycle k+SETUP_CYC+EN_CYC+HOLD_CYC+1. With defaults, that is the 5th cycle after the sampling edge.
- Requesters drop valid on the edge that samples ack. The following IDLE cycle arbitrates among the remaining requesters with no bubble beyond that IDLE cycle.
- Invariants: latch_s & latch_r never both 1. S/R never change while latch_en=1. latch_en is never high outside ENABLE.
- A requester dropping valid after grant does not abort the transaction; it still runs and acks.
- Valid changes on non-granted requesters during a transaction are ignored until IDLE.
- Phase counter width is $clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC)+1). The counter reloads on each phase entry.

Decomposition:
- Shared package: FSM state enum (IDLE, SETUP, ENABLE, HOLD, CHECK) and OP_SET/OP_CLR constants.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin, pointer update on grant), reusable elsewhere.
- Phase counter and FSM stay in the top module.

Test Plan:
- Reset, then req_valid=0001 with op=1, and the latch model behaves correctly -> S=1/R=0 for 1 cycle, EN=1 for 2 cycles, hold 1 cycle; ack[0] on cycle 5 with req_err=0; latch Q=1.
- req_valid=1111 held constant with all ops=0 -> acks in order 0,1,2,3,0 (pointer 0 after reset), one per 6 cycles; S never high.
- Latch model stuck at Q=0, op=1 -> req_err=1 with ack; err_cnt=1. Repeat 300 times -> err_cnt saturates at 255.
- Assert reset during ENABLE -> latch_en, S, R and busy are 0 the next cycle; ack never fires; next request starts with pointer 0.
- Requester 2 drops valid during SETUP -> transaction completes and ack[2] still pulses; requester 1 raised mid-transaction is granted in the following IDLE.
- Assertion checks across all tests: never S&R; S/R stable while EN=1; req_ack one-hot or zero; busy=0 only in IDLE.
